// File: rtl/accum_frame_sequencer.sv
// Frame sequencer around a DW-bit up-accumulator: feeds WINDOW samples, captures Q, then clears.
// Optional overflow flag M_OVF is compiled in with `define ACCUM_FRAME_SEQ_OVF_EN.
module accum_frame_sequencer #(
    parameter int unsigned DW     = 4,
    parameter int unsigned WINDOW = 4,
    parameter int unsigned CW     = 8
) (
    input  logic          C,
    input  logic          CLR,
    input  logic [DW-1:0] S_DATA,
    input  logic          S_VALID,
    output logic          S_READY,
    output logic [DW-1:0] ACC_D,
    output logic          ACC_CLR,
    input  logic [DW-1:0] ACC_Q,
    output logic [DW-1:0] M_DATA,
    output logic          M_VALID,
`ifdef ACCUM_FRAME_SEQ_OVF_EN
    output logic          M_OVF,
`endif
    input  logic          M_READY
);

    typedef enum logic [2:0] {
        ST_INIT,
        ST_COLLECT,
        ST_DRAIN,
        ST_CAPTURE,
        ST_DUMP
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(WINDOW - 1);

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [DW-1:0] r_acc_d, w_acc_d_nxt;
    logic [DW-1:0] r_m_data, w_m_data_nxt;
    logic          r_acc_clr, w_acc_clr_nxt;
    logic          r_m_valid, w_m_valid_nxt;
    logic          w_accept;
    logic          w_release;

    assign S_READY   = (r_state == ST_COLLECT);
    assign w_accept  = S_VALID & S_READY;
    assign w_release = r_m_valid & M_READY;

    assign ACC_D   = r_acc_d;
    assign ACC_CLR = r_acc_clr;
    assign M_DATA  = r_m_data;
    assign M_VALID = r_m_valid;

    always_comb begin
        // NOTE: every next-state value gets a default before the case so no latch is inferred.
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_acc_d_nxt   = '0;
        w_acc_clr_nxt = r_acc_clr;
        w_m_data_nxt  = r_m_data;
        w_m_valid_nxt = r_m_valid;

        case (r_state)
            ST_INIT: begin
                w_acc_clr_nxt = 1'b0;
                w_state_nxt   = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    w_acc_d_nxt = S_DATA;
                    if (r_cnt == LAST_IDX) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end
            end
            // Last addend is still on ACC_D here; the accumulator absorbs it at this edge.
            ST_DRAIN: begin
                w_state_nxt = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                w_m_data_nxt  = ACC_Q;
                w_m_valid_nxt = 1'b1;
                w_acc_clr_nxt = 1'b1;
                w_state_nxt   = ST_DUMP;
            end
            ST_DUMP: begin
                if (w_release) begin
                    w_m_valid_nxt = 1'b0;
                    w_acc_clr_nxt = 1'b0;
                    w_state_nxt   = ST_COLLECT;
                end
            end
            default: begin
                w_acc_clr_nxt = 1'b1;
                w_m_valid_nxt = 1'b0;
                w_cnt_nxt     = '0;
                w_state_nxt   = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge C) begin
        if (!CLR) begin
            r_state   <= ST_INIT;
            r_cnt     <= '0;
            r_acc_d   <= '0;
            r_acc_clr <= 1'b1;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_acc_d   <= w_acc_d_nxt;
            r_acc_clr <= w_acc_clr_nxt;
            r_m_data  <= w_m_data_nxt;
            r_m_valid <= w_m_valid_nxt;
        end
    end

`ifdef ACCUM_FRAME_SEQ_OVF_EN
    localparam logic [DW+CW-1:0] SUM_MAX = {{CW{1'b0}}, {DW{1'b1}}};

    // Full-width mirror of the frame sum so wrap in the DW-bit accumulator can be detected.
    logic [DW+CW-1:0] r_shadow;
    logic             r_m_ovf;

    assign M_OVF = r_m_ovf;

    always_ff @(posedge C) begin
        if (!CLR) begin
            r_shadow <= '0;
            r_m_ovf  <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: r_shadow <= '0;
                ST_COLLECT: begin
                    if (w_accept) begin
                        r_shadow <= r_shadow + (DW+CW)'(S_DATA);
                    end
                end
                ST_CAPTURE: r_m_ovf <= (r_shadow > SUM_MAX);
                ST_DUMP: begin
                    if (w_release) begin
                        r_shadow <= '0;
                        r_m_ovf  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    // Overflow tracking compiled out; frame sums simply wrap at 2^DW.
`endif

endmodule

// File: doc/accum_frame_sequencer.md
Name: accum_frame_sequencer

Overview:
- Control stage wrapped around the 4-bit unsigned up-accumulator. It sits directly upstream of the accumulator's D/CLR inputs and directly downstream of its Q output.
- Accepts a valid/ready sample stream and feeds exactly WINDOW samples into the accumulator, driving D = 0 on idle cycles.
- After the window, captures the accumulator's Q as a frame sum, presents it on a valid/ready output, then clears the accumulator for the next frame.

Parameters:
- DW, 4: sample width and accumulator width (ACC_D, ACC_Q, S_DATA, M_DATA).
- WINDOW, 4: samples per frame; legal range 1..255.
- CW, 8: frame sample counter width; must satisfy 2^CW > WINDOW.

Ports:
- C  in  1  clock; all state updates on rising edge.
- CLR  in  1  reset, synchronous, active-low.
- S_DATA  in  DW  input sample.
- S_VALID  in  1  sample valid.
- S_READY  out  1  sample ready; combinational, high only in COLLECT.
- ACC_D  out  DW  registered addend to accumulator D.
- ACC_CLR  out  1  registered, active-high clear to accumulator CLR.
- ACC_Q  in  DW  accumulator Q.
- M_DATA  out  DW  captured frame sum.
- M_VALID  out  1  frame sum valid.
- M_READY  in  1  downstream ready.

Behaviour:
- Reset (CLR low at a C edge) sets:
  - state = INIT, cnt = 0
  - ACC_D = 0, ACC_CLR = 1
  - M_VALID = 0, M_DATA = 0
- Reset mid-frame or mid-DUMP discards the partial or pending frame; no M_VALID pulse follows.
- INIT: ACC_CLR = 1 for one cycle, then -> COLLECT with ACC_CLR = 0 and shadow sum = 0.
- COLLECT: S_READY = 1.
  - On S_VALID & S_READY: ACC_D <= S_DATA, cnt++.
  - Otherwise: ACC_D <= 0, so gaps do not disturb the sum.
  - Accept with cnt == WINDOW-1 -> DRAIN, cnt <= 0. With WINDOW = 1, the first accept goes straight to DRAIN.
- DRAIN: one cycle. ACC_D still holds the last sample, which the accumulator adds at this cycle's closing edge. ACC_D <= 0.
- CAPTURE: one cycle. ACC_Q is now final. At the closing edge:
  - M_DATA <= ACC_Q, M_VALID <= 1, ACC_CLR <= 1
  - -> DUMP
- DUMP: M_DATA, M_VALID and ACC_CLR held. S_READY = 0; S_VALID is ignored.
  - On M_VALID & M_READY: M_VALID <= 0, ACC_CLR <= 0, -> COLLECT next cycle.
- Latency: last sample accepted at edge k -> M_VALID high after edge k+2.
- Minimum frame period: WINDOW + 3 cycles.
- Arithmetic: frame sum is modulo 2^DW (accumulator wrap). The block does not saturate.
- M_DATA is never modified while M_VALID = 1.
- ACC_CLR and ACC_D are never both nonzero in the same cycle.

Optional Feature:
- Macro: ACCUM_FRAME_SEQ_OVF_EN.
- Defined:
  - Adds output port M_OVF (1 bit).
  - Internal shadow sum, width DW+CW, is cleared on entry to COLLECT and adds every accepted S_DATA.
  - At CAPTURE, M_OVF <= (shadow > 2^DW - 1). M_OVF follows M_VALID timing and is 0 on reset.
- Undefined: no M_OVF port and no shadow register; behaviour otherwise identical.

Test Plan (DW = 4, WINDOW = 4):
- Samples 1,2,3,4 on consecutive cycles, M_READY = 1 -> M_DATA = 10, M_VALID for 1 cycle, 2 cycles after the 4th accept; M_OVF = 0.
- Samples 5,6,7,8 -> M_DATA = 10 (26 mod 16); M_OVF = 1 when ACCUM_FRAME_SEQ_OVF_EN is defined.
- Samples 3,3,3,3 with S_VALID low 2 cycles between each -> ACC_D = 0 in the gaps, M_DATA = 12.
- M_READY low 5 cycles after M_VALID rises -> M_DATA stable, S_READY = 0, ACC_CLR = 1 throughout. M_READY high -> handshake, next frame 2,2,2,2 gives M_DATA = 8.
- CLR low for 1 edge after 2 accepted samples -> M_VALID = 0, ACC_CLR = 1. Following frame 1,1,1,1 -> M_DATA = 4 (no carry-over).
- WINDOW = 1 build: single sample 9 -> M_DATA = 9; S_READY stays low until the dump is accepted.
